// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg
// Shared definitions for the I2C command sequencer slice.
//   seq_state_t            : sequencer FSM states (S_IDLE..S_RESP)
//   CMD_W                  : width of one queued command entry
//   cmd_t                  : packed command entry {rw, addr[6:0], data[7:0]}
//   DEFAULT_TIMEOUT_CYCLES : default abort limit for S_ISSUE / S_WAIT
//   DEFAULT_FIFO_DEPTH     : default command FIFO depth
//   pack_cmd()             : builds a command entry from its fields
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } seq_state_t;

  localparam int CMD_W                  = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
  localparam int DEFAULT_FIFO_DEPTH     = 4;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  function automatic cmd_t pack_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    cmd_t c;
    c.rw   = rw;
    c.addr = addr;
    c.data = data;
    return c;
  endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo
// Small synchronous FIFO holding queued I2C commands.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   i_push    : write i_wdata (ignored when full)
//   i_wdata   : entry to write
//   i_pop     : drop the head entry (ignored when empty)
//   o_rdata   : current head entry (valid when not empty)
//   o_full    : no free entries
//   o_empty   : no stored entries
//   o_count   : occupancy, 0..DEPTH
module i2c_cmd_fifo
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = CMD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;
  assign o_rdata  = r_mem[r_rdPtr];
  assign o_count  = r_count;

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two. A push and pop
  // in the same cycle move both pointers and leave the count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer
// Front-end that queues single-byte I2C commands and feeds them one at a time
// to the byte-level I2C master over its enable/ready handshake, returning one
// response (read byte or timeout flag) per command.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready        : command handshake (ready = FIFO not full)
//   i_cmd_addr/i_cmd_rw/i_cmd_data : command fields
//   o_rsp_valid/i_rsp_ready        : response handshake
//   o_rsp_data/o_rsp_rw/o_rsp_timeout : response fields, held while pending
//   o_m_addr/o_m_data/o_m_rw/o_m_enable : drive to the controller
//   i_m_ready/i_m_rdata            : status/read data from the controller
//   o_busy                         : work queued or in progress
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [6:0] i_cmd_addr,
  input  logic       i_cmd_rw,
  input  logic [7:0] i_cmd_data,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_rw,
  output logic       o_rsp_timeout,
  output logic [6:0] o_m_addr,
  output logic [7:0] o_m_data,
  output logic       o_m_rw,
  output logic       o_m_enable,
  input  logic       i_m_ready,
  input  logic [7:0] i_m_rdata,
  output logic       o_busy
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_t                    r_state;
  seq_state_t                    w_nextState;
  logic [TW-1:0]                 r_tmoCount;
  logic                          w_tmoHit;
  logic                          w_tmoClear;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_fifoFull;
  logic                          w_fifoEmpty;
  logic [$clog2(FIFO_DEPTH):0]   w_fifoCount;
  logic [CMD_W-1:0]              w_headBits;
  cmd_t                          w_head;
  cmd_t                          w_newCmd;
  logic [6:0]                    r_mAddr;
  logic [7:0]                    r_mData;
  logic                          r_mRw;
  logic                          w_rspLoad;
  logic                          w_rspTimeout;
  logic [7:0]                    w_rspData;
  logic [7:0]                    r_rspData;
  logic                          r_rspRw;
  logic                          r_rspTimeout;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign o_cmd_ready = ~rst & ~w_fifoFull;
  assign w_push      = i_cmd_valid & o_cmd_ready;
  assign w_newCmd    = pack_cmd(i_cmd_rw, i_cmd_addr, i_cmd_data);
  assign w_head      = cmd_t'(w_headBits);

  i2c_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_newCmd),
    .i_pop   (w_pop),
    .o_rdata (w_headBits),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty),
    .o_count (w_fifoCount)
  );

  assign w_tmoHit = (r_tmoCount == TMO_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control decode. A pop only happens from S_IDLE with the
  // controller reporting ready, so a controller still finishing its STOP holds
  // the queue. Leaving enable low in S_WAIT makes the controller end every
  // transaction with a STOP. A controller response in the same cycle as the
  // timeout wins over the abort.
  always_comb begin
    w_nextState  = r_state;
    w_pop        = 1'b0;
    w_tmoClear   = 1'b0;
    w_rspLoad    = 1'b0;
    w_rspTimeout = 1'b0;
    w_rspData    = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (!w_fifoEmpty && i_m_ready) begin
          w_pop       = 1'b1;
          w_tmoClear  = 1'b1;
          w_nextState = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!i_m_ready) begin
          w_tmoClear  = 1'b1;
          w_nextState = S_WAIT;
        end else if (w_tmoHit) begin
          w_rspLoad    = 1'b1;
          w_rspTimeout = 1'b1;
          w_nextState  = S_RESP;
        end
      end
      S_WAIT: begin
        if (i_m_ready) begin
          w_rspLoad   = 1'b1;
          w_rspData   = r_mRw ? i_m_rdata : 8'h00;
          w_nextState = S_RESP;
        end else if (w_tmoHit) begin
          w_rspLoad    = 1'b1;
          w_rspTimeout = 1'b1;
          w_nextState  = S_RESP;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Timeout counter: restarted on entry to S_ISSUE and S_WAIT, counting every
  // cycle spent in either; the abort fires on the edge where it reads
  // TIMEOUT_CYCLES-1, giving exactly TIMEOUT_CYCLES cycles in the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmoCount <= '0;
    end else if (w_tmoClear) begin
      r_tmoCount <= '0;
    end else if (r_state == S_ISSUE || r_state == S_WAIT) begin
      r_tmoCount <= r_tmoCount + 1'b1;
    end
  end

  // Controller command registers, loaded from the FIFO head at the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mAddr <= 7'h00;
      r_mData <= 8'h00;
      r_mRw   <= 1'b0;
    end else if (w_pop) begin
      r_mAddr <= w_head.addr;
      r_mData <= w_head.data;
      r_mRw   <= w_head.rw;
    end
  end

  // Response register, loaded only on entry to S_RESP so it stays stable
  // for as long as the response waits to be consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rspData    <= 8'h00;
      r_rspRw      <= 1'b0;
      r_rspTimeout <= 1'b0;
    end else if (w_rspLoad) begin
      r_rspData    <= w_rspData;
      r_rspRw      <= r_mRw;
      r_rspTimeout <= w_rspTimeout;
    end
  end

  assign o_m_addr      = r_mAddr;
  assign o_m_data      = r_mData;
  assign o_m_rw        = r_mRw;
  assign o_m_enable    = (r_state == S_ISSUE);
  assign o_rsp_valid   = (r_state == S_RESP);
  assign o_rsp_data    = r_rspData;
  assign o_rsp_rw      = r_rspRw;
  assign o_rsp_timeout = r_rspTimeout;
  assign o_busy        = (w_fifoCount != '0) | (r_state != S_IDLE);

endmodule
